// File: rtl/hex_display_ctrl_if.sv
// Sample handshake between the ADC sample path (master) and the
// hex display sequencer (slave). The master offers in_data with in_valid
// and holds both until the sequencer raises in_ready.
interface hex_display_ctrl_if #(
  parameter int IN_W = 12
) ();

  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: accepts a binary ADC sample and converts it to four BCD
// digits with one shift-and-add-3 (double dabble) step per clock. It commits
// the digits to bcd_digits and then holds them for REFRESH_DIV cycles so the
// display does not flicker.
// Optional feature: define ZERO_BLANK_EN to produce a registered
// leading-zero blank mask on digit_blank. Without it, digit_blank is
// tied to 4'b0000. Forcing the blanked segments to 8'hFF happens
// downstream, at the per-digit decoders.
module hex_display_ctrl #(
  parameter int IN_W        = 12,
  parameter int REFRESH_DIV = 5_000_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  hex_display_ctrl_if.slave        in_if,
  output logic [15:0]              bcd_digits,
  output logic                     update_pulse,
  output logic                     busy,
  output logic [3:0]               digit_blank
);

  localparam int BIT_W  = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int HOLD_W = (REFRESH_DIV > 0) ? $clog2(REFRESH_DIV + 1) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(IN_W - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (REFRESH_DIV > 0) ? HOLD_W'(REFRESH_DIV - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT,
    HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [IN_W-1:0]   shift_q, shift_d;
  logic [15:0]       scratch_q, scratch_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [15:0]       bcd_q, bcd_d;
  logic              pulse_q, pulse_d;
  logic [15:0]       adjusted;

  // Add 3 to every scratch nibble that is 5 or more, so the following left shift carries correctly into the next decimal digit
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        adjusted[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // State register and datapath registers; reset discards any partial conversion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      bcd_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      bcd_q      <= bcd_d;
      pulse_q    <= pulse_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate IN_W times, commit once, then hold for the refresh interval
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    bcd_d      = bcd_q;
    pulse_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_if.in_valid) begin
          shift_d   = in_if.in_data;
          scratch_d = '0;
          bit_cnt_d = '0;
          state_d   = CONVERT;
        end
      end

      CONVERT: begin
        scratch_d = (adjusted << 1) | {15'd0, shift_q[IN_W-1]};
        shift_d   = shift_q << 1;
        if (bit_cnt_q == BIT_LAST) begin
          state_d = COMMIT;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      COMMIT: begin
        bcd_d      = scratch_q;
        pulse_d    = 1'b1;
        hold_cnt_d = '0;
        state_d    = (REFRESH_DIV == 0) ? IDLE : HOLD;
      end

      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_if.in_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign bcd_digits     = bcd_q;
  assign update_pulse   = pulse_q;

`ifdef ZERO_BLANK_EN
  logic [3:0] blank_q;
  logic       zero_thou;
  logic       zero_hund;
  logic       zero_tens;

  assign zero_thou = (scratch_q[15:12] == 4'd0);
  assign zero_hund = (scratch_q[11:8]  == 4'd0);
  assign zero_tens = (scratch_q[7:4]   == 4'd0);

  // Leading-zero mask is captured alongside bcd_digits in COMMIT; the units digit always stays lit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 4'b1110;
    end else if (state_q == COMMIT) begin
      blank_q <= {zero_thou,
                  zero_thou && zero_hund,
                  zero_thou && zero_hund && zero_tens,
                  1'b0};
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = 4'b0000;
`endif

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed testbench for hex_display_ctrl. dutHold uses REFRESH_DIV=4 for
// the latency, hold, handshake and reset scenarios. dutSweep uses
// REFRESH_DIV=0 and converts every 12-bit value against a decimal model.
// It honours ZERO_BLANK_EN for the expected digit_blank values.
module tb_hex_display_ctrl;

`ifdef ZERO_BLANK_EN
  localparam logic [3:0] BLANK_RST  = 4'b1110;
  localparam logic [3:0] BLANK_0    = 4'b1110;
  localparam logic [3:0] BLANK_4095 = 4'b0000;
  localparam logic [3:0] BLANK_1234 = 4'b0000;
  localparam logic [3:0] BLANK_42   = 4'b1100;
  localparam logic [3:0] BLANK_987  = 4'b1000;
`else
  localparam logic [3:0] BLANK_RST  = 4'b0000;
  localparam logic [3:0] BLANK_0    = 4'b0000;
  localparam logic [3:0] BLANK_4095 = 4'b0000;
  localparam logic [3:0] BLANK_1234 = 4'b0000;
  localparam logic [3:0] BLANK_42   = 4'b0000;
  localparam logic [3:0] BLANK_987  = 4'b0000;
`endif

  logic clk = 1'b0;
  logic reset_n;

  logic [15:0] holdBcd;
  logic        holdPulse;
  logic        holdBusy;
  logic [3:0]  holdBlank;

  logic [15:0] sweepBcd;
  logic        sweepPulse;
  logic        sweepBusy;
  logic [3:0]  sweepBlank;

  int checkCount   = 0;
  int errorCount   = 0;
  int edgeCount    = 0;
  int pulseCount   = 0;
  int lastPulseEdge = -1;
  int busyErr      = 0;
  logic [15:0] lastBcd;
  logic [3:0]  lastBlank;

  hex_display_ctrl_if #(.IN_W(12)) holdIf ();
  hex_display_ctrl_if #(.IN_W(12)) sweepIf ();

  always #5 clk = ~clk;

  hex_display_ctrl #(.IN_W(12), .REFRESH_DIV(4)) dutHold (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_if        (holdIf),
    .bcd_digits   (holdBcd),
    .update_pulse (holdPulse),
    .busy         (holdBusy),
    .digit_blank  (holdBlank)
  );

  hex_display_ctrl #(.IN_W(12), .REFRESH_DIV(0)) dutSweep (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_if        (sweepIf),
    .bcd_digits   (sweepBcd),
    .update_pulse (sweepPulse),
    .busy         (sweepBusy),
    .digit_blank  (sweepBlank)
  );

  // Counts one comparison and reports it when observed differs from expected
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advances one clock and samples 1 time unit after the rising edge, logging any update pulse of dutHold
  task automatic tick();
    @(posedge clk);
    edgeCount++;
    #1;
    if (holdPulse === 1'b1) begin
      pulseCount++;
      lastPulseEdge = edgeCount;
      lastBcd       = holdBcd;
      lastBlank     = holdBlank;
    end
    if (holdBusy === holdIf.in_ready) begin
      busyErr++;
    end
  endtask

  // Offers a sample to dutHold and returns the edge number at which it was accepted (valid stays high)
  task automatic applyStimulus(input logic [11:0] value, input int budget,
                               output int acceptEdge);
    logic sawReady;
    holdIf.in_data  = value;
    holdIf.in_valid = 1'b1;
    acceptEdge      = -1;
    for (int i = 0; i < budget; i++) begin
      sawReady = holdIf.in_ready;
      tick();
      if (sawReady) begin
        acceptEdge = edgeCount;
        break;
      end
    end
    if (acceptEdge < 0) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  // Waits, bounded, for the next update pulse from dutHold
  task automatic waitPulse(input int budget);
    int startCount;
    startCount = pulseCount;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pulseCount > startCount) begin
        break;
      end
    end
    if (pulseCount == startCount) begin
      checkOutput("pulse_timeout", 32'd0, 32'd1);
    end
  endtask

  // Decimal reference: split a value into thousands, hundreds, tens and units
  function automatic logic [15:0] toBcd(input int v);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    int accA;
    int accB;
    int startEdge;
    int startPulses;
    int prevAcc;
    int acc;
    int spacingErr;
    int nibbleErr;
    int pulseErr;
    logic sawReady;

    reset_n          = 1'b0;
    holdIf.in_data   = '0;
    holdIf.in_valid  = 1'b0;
    sweepIf.in_data  = '0;
    sweepIf.in_valid = 1'b0;

    repeat (2) tick();
    checkOutput("rst_ready", 32'(holdIf.in_ready), 32'd1);
    checkOutput("rst_bcd",   32'(holdBcd),         32'h0000);
    checkOutput("rst_pulse", 32'(holdPulse),       32'd0);
    checkOutput("rst_busy",  32'(holdBusy),        32'd0);
    checkOutput("rst_blank", 32'(holdBlank),       32'(BLANK_RST));
    reset_n = 1'b1;

    // Zero is accepted on the first edge and shows up 13 edges later
    startEdge = edgeCount;
    applyStimulus(12'd0, 5, accA);
    holdIf.in_valid = 1'b0;
    checkOutput("t1_first_edge", 32'(accA - startEdge), 32'd1);
    checkOutput("t1_busy", 32'(holdBusy), 32'd1);
    waitPulse(20);
    checkOutput("t1_latency", 32'(lastPulseEdge - accA), 32'd13);
    checkOutput("t1_bcd",     32'(lastBcd),   32'h0000);
    checkOutput("t1_blank",   32'(lastBlank), 32'(BLANK_0));
    checkOutput("t1_pulse_count", 32'(pulseCount), 32'd1);
    tick();
    checkOutput("t1_pulse_width", 32'(holdPulse), 32'd0);

    // Full-scale sample
    applyStimulus(12'd4095, 40, accA);
    holdIf.in_valid = 1'b0;
    checkOutput("t2_busy", 32'(holdBusy), 32'd1);
    waitPulse(20);
    checkOutput("t2_latency", 32'(lastPulseEdge - accA), 32'd13);
    checkOutput("t2_bcd",     32'(lastBcd),   32'h4095);
    checkOutput("t2_blank",   32'(lastBlank), 32'(BLANK_4095));

    // Back-to-back with valid held: second accept waits out CONVERT, COMMIT and HOLD
    applyStimulus(12'd1234, 40, accA);
    applyStimulus(12'd42, 40, accB);
    holdIf.in_valid = 1'b0;
    checkOutput("t3_spacing",      32'(accB - accA), 32'd18);
    checkOutput("t3_first_latency", 32'(lastPulseEdge - accA), 32'd13);
    checkOutput("t3_first_bcd",    32'(lastBcd),   32'h1234);
    checkOutput("t3_first_blank",  32'(lastBlank), 32'(BLANK_1234));
    waitPulse(20);
    checkOutput("t3_second_latency", 32'(lastPulseEdge - accB), 32'd13);
    checkOutput("t3_second_bcd",   32'(lastBcd),   32'h0042);
    checkOutput("t3_second_blank", 32'(lastBlank), 32'(BLANK_42));

    // Reset during CONVERT iteration 6 of 987
    applyStimulus(12'd987, 40, accA);
    holdIf.in_valid = 1'b0;
    repeat (6) tick();
    reset_n = 1'b0;
    #1;
    checkOutput("t4_ready", 32'(holdIf.in_ready), 32'd1);
    checkOutput("t4_busy",  32'(holdBusy),        32'd0);
    checkOutput("t4_bcd",   32'(holdBcd),         32'h0000);
    checkOutput("t4_pulse", 32'(holdPulse),       32'd0);
    checkOutput("t4_blank", 32'(holdBlank),       32'(BLANK_RST));
    repeat (2) tick();
    reset_n = 1'b1;
    startPulses = pulseCount;
    repeat (20) tick();
    checkOutput("t4_no_pulse", 32'(pulseCount - startPulses), 32'd0);
    checkOutput("t4_bcd_idle", 32'(holdBcd), 32'h0000);
    applyStimulus(12'd987, 5, accA);
    holdIf.in_valid = 1'b0;
    waitPulse(20);
    checkOutput("t4_latency", 32'(lastPulseEdge - accA), 32'd13);
    checkOutput("t4_bcd",     32'(lastBcd),   32'h0987);
    checkOutput("t4_blank",   32'(lastBlank), 32'(BLANK_987));
    checkOutput("busy_vs_ready", 32'(busyErr), 32'd0);

    // Sweep every 12-bit value through the no-hold instance with valid held high
    spacingErr = 0;
    nibbleErr  = 0;
    pulseErr   = 0;
    prevAcc    = -1;
    sweepIf.in_valid = 1'b1;
    for (int v = 0; v < 4096; v++) begin
      sweepIf.in_data = 12'(v);
      acc = -1;
      for (int i = 0; i < 20; i++) begin
        sawReady = sweepIf.in_ready;
        tick();
        if (sawReady) begin
          acc = edgeCount;
          break;
        end
      end
      if (acc < 0) begin
        checkOutput("t5_accept_timeout", 32'd0, 32'd1);
        break;
      end
      if (prevAcc >= 0 && (acc - prevAcc) != 14) begin
        spacingErr++;
      end
      prevAcc = acc;
      repeat (13) tick();
      if (sweepPulse !== 1'b1) begin
        pulseErr++;
      end
      checkOutput($sformatf("t5_bcd_%0d", v), 32'(sweepBcd), 32'(toBcd(v)));
      for (int n = 0; n < 4; n++) begin
        if (sweepBcd[n*4 +: 4] > 4'd9) begin
          nibbleErr++;
        end
      end
    end
    sweepIf.in_valid = 1'b0;
    checkOutput("t5_spacing", 32'(spacingErr), 32'd0);
    checkOutput("t5_nibbles", 32'(nibbleErr),  32'd0);
    checkOutput("t5_pulses",  32'(pulseErr),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
